// File: rtl/regfile_sb.sv
// Register file with a per-register pending scoreboard, write-first read bypass
// and a sequential bulk-clear engine that zeroes one entry per cycle.
//
// state | meaning
// IDLE  | available; writes, allocs and clr_req accepted
// CLEAR | zeroing entry idx each cycle; writes and allocs dropped
// DONE  | clear finished; clr_done pulses, back to IDLE next cycle
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic              rd_pend1,
   output logic              rd_pend2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              alloc_en,
   input  logic [ADDR_W-1:0] alloc_addr,
   input  logic              flush,
   input  logic              clr_req,
   output logic              rdy,
   output logic              clr_done
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] IDX_LAST = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] idx, idx_nxt;
   logic              clr_active;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  pend, pend_nxt;

   logic              wr_ok, alloc_ok;
   logic              zero1, zero2, byp1, byp2;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      rdy        = 1'b0;
      clr_done   = 1'b0;
      clr_active = 1'b0;
      case (state)
         IDLE: begin
            rdy = 1'b1;
            if (clr_req) begin
               state_nxt = CLEAR;
               idx_nxt   = '0;
            end
         end
         CLEAR: begin
            clr_active = 1'b1;
            // idx parks on the last entry rather than wrapping
            if (idx == IDX_LAST) begin
               state_nxt = DONE;
            end else begin
               idx_nxt = idx + 1'b1;
            end
         end
         DONE: begin
            clr_done  = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign wr_ok    = wr_en && rdy && !((ZERO_REG != 0) && (wr_addr == '0));
   assign alloc_ok = alloc_en && rdy && !((ZERO_REG != 0) && (alloc_addr == '0));

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (wr_ok) begin
            mem[wr_addr] <= wr_data;
         end
         if (clr_active) begin
            mem[idx] <= '0;
         end
      end
   end

   // alloc is applied last so a new producer wins over flush and writeback
   always_comb begin
      pend_nxt = pend;
      if (flush) begin
         pend_nxt = '0;
      end
      if (wr_ok) begin
         pend_nxt[wr_addr] = 1'b0;
      end
      if (clr_active) begin
         pend_nxt[idx] = 1'b0;
      end
      if (alloc_ok) begin
         pend_nxt[alloc_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend <= '0;
      end else begin
         pend <= pend_nxt;
      end
   end

   assign zero1 = (ZERO_REG != 0) && (rd_addr1 == '0);
   assign zero2 = (ZERO_REG != 0) && (rd_addr2 == '0);
   assign byp1  = (BYPASS != 0) && wr_ok && (wr_addr == rd_addr1);
   assign byp2  = (BYPASS != 0) && wr_ok && (wr_addr == rd_addr2);

   assign rd_data1 = zero1 ? '0 : (byp1 ? wr_data : mem[rd_addr1]);
   assign rd_data2 = zero2 ? '0 : (byp2 ? wr_data : mem[rd_addr2]);
   assign rd_pend1 = (zero1 || byp1) ? 1'b0 : pend[rd_addr1];
   assign rd_pend2 = (zero2 || byp2) ? 1'b0 : pend[rd_addr2];

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a default instance and a ZERO_REG=0/BYPASS=0 instance
// driven in lockstep and compared against an array-based reference model.
module tb_regfile_sb;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] rd_addr1, rd_addr2, wr_addr, alloc_addr;
   logic [DW-1:0] wr_data;
   logic          wr_en, alloc_en, flush, clr_req;

   logic [DW-1:0] rd_data1_a, rd_data2_a, rd_data1_b, rd_data2_b;
   logic          rd_pend1_a, rd_pend2_a, rd_pend1_b, rd_pend2_b;
   logic          rdy_a, rdy_b, clr_done_a, clr_done_b;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] ma [DEPTH];
   logic [DW-1:0] mb [DEPTH];
   bit            pa [DEPTH];
   bit            pb [DEPTH];
   int            now    = 0;
   int            clr_s  = -1000;
   bit            mvalid = 1'b0;
   int            low, done;

   regfile_sb u_a (
      .clk(clk), .reset(reset),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd_data1_a), .rd_data2(rd_data2_a),
      .rd_pend1(rd_pend1_a), .rd_pend2(rd_pend2_a),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr),
      .flush(flush), .clr_req(clr_req),
      .rdy(rdy_a), .clr_done(clr_done_a)
   );

   regfile_sb #(.ZERO_REG(0), .BYPASS(0)) u_b (
      .clk(clk), .reset(reset),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd_data1_b), .rd_data2(rd_data2_b),
      .rd_pend1(rd_pend1_b), .rd_pend2(rd_pend2_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr),
      .flush(flush), .clr_req(clr_req),
      .rdy(rdy_b), .clr_done(clr_done_b)
   );

   always #5 clk = ~clk;

   // Unavailable from the cycle after the accepting edge through the done cycle.
   function automatic bit m_busy();
      return (now >= clr_s) && (now <= clr_s + DEPTH);
   endfunction

   function automatic bit m_done();
      return now == clr_s + DEPTH;
   endfunction

   function automatic logic [DW-1:0] exp_data(input bit cfg_b, input logic [AW-1:0] a);
      if (cfg_b) return mb[a];
      if (a == 0) return '0;
      if (!m_busy() && wr_en && wr_addr == a) return wr_data;
      return ma[a];
   endfunction

   function automatic logic exp_pend(input bit cfg_b, input logic [AW-1:0] a);
      if (cfg_b) return pb[a];
      if (a == 0) return 1'b0;
      if (!m_busy() && wr_en && wr_addr == a) return 1'b0;
      return pa[a];
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("a.rd_data1", rd_data1_a, exp_data(1'b0, rd_addr1));
      chk("a.rd_data2", rd_data2_a, exp_data(1'b0, rd_addr2));
      chk("a.rd_pend1", {31'd0, rd_pend1_a}, {31'd0, exp_pend(1'b0, rd_addr1)});
      chk("a.rd_pend2", {31'd0, rd_pend2_a}, {31'd0, exp_pend(1'b0, rd_addr2)});
      chk("a.rdy", {31'd0, rdy_a}, {31'd0, !m_busy()});
      chk("a.clr_done", {31'd0, clr_done_a}, {31'd0, m_done()});
      chk("b.rd_data1", rd_data1_b, exp_data(1'b1, rd_addr1));
      chk("b.rd_data2", rd_data2_b, exp_data(1'b1, rd_addr2));
      chk("b.rd_pend1", {31'd0, rd_pend1_b}, {31'd0, exp_pend(1'b1, rd_addr1)});
      chk("b.rd_pend2", {31'd0, rd_pend2_b}, {31'd0, exp_pend(1'b1, rd_addr2)});
      chk("b.rdy", {31'd0, rdy_b}, {31'd0, !m_busy()});
      chk("b.clr_done", {31'd0, clr_done_b}, {31'd0, m_done()});
   endtask

   task automatic model_edge();
      int nxt;
      int k;
      bit r;
      nxt = now + 1;
      r   = !m_busy();
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            ma[i] = '0; mb[i] = '0; pa[i] = 1'b0; pb[i] = 1'b0;
         end
         clr_s  = -1000;
         mvalid = 1'b1;
      end else begin
         if (r && wr_en) begin
            if (wr_addr != 0) begin
               ma[wr_addr] = wr_data;
               pa[wr_addr] = 1'b0;
            end
            mb[wr_addr] = wr_data;
            pb[wr_addr] = 1'b0;
         end
         if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
               pa[i] = 1'b0; pb[i] = 1'b0;
            end
         end
         k = nxt - clr_s - 1;
         if (k >= 0 && k < DEPTH) begin
            ma[k] = '0; mb[k] = '0; pa[k] = 1'b0; pb[k] = 1'b0;
         end
         if (r && alloc_en) begin
            if (alloc_addr != 0) pa[alloc_addr] = 1'b1;
            pb[alloc_addr] = 1'b1;
         end
         if (r && clr_req) clr_s = nxt;
      end
      now = nxt;
   endtask

   task automatic cycle();
      #1;
      if (mvalid) check_all();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      reset = 1'b0; wr_en = 1'b0; alloc_en = 1'b0; flush = 1'b0; clr_req = 1'b0;
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; alloc_en = 1'b0;
      alloc_addr = '0; flush = 1'b0; clr_req = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
      cycle();
      cycle();

      idle(); rd_addr1 = 5'd5; rd_addr2 = 5'd9;
      #1;
      chk("reset rd_data1", rd_data1_a, 32'd0);
      chk("reset rd_pend2", {31'd0, rd_pend2_a}, 32'd0);
      chk("reset rdy", {31'd0, rdy_a}, 32'd1);
      chk("reset clr_done", {31'd0, clr_done_a}, 32'd0);
      cycle();

      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
      cycle();
      idle(); rd_addr1 = 5'd5; rd_addr2 = 5'd5;
      #1;
      chk("basic rd_data1", rd_data1_a, 32'hDEADBEEF);
      chk("basic rd_data2", rd_data2_a, 32'hDEADBEEF);
      chk("basic rd_pend1", {31'd0, rd_pend1_a}, 32'd0);
      cycle();

      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; alloc_en = 1'b1; alloc_addr = 5'd0;
      cycle();
      idle(); rd_addr1 = 5'd0;
      #1;
      chk("zero reg data", rd_data1_a, 32'd0);
      chk("zero reg pend", {31'd0, rd_pend1_a}, 32'd0);
      chk("plain r0 data", rd_data1_b, 32'h1234);
      cycle();

      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11;
      cycle();
      wr_data = 32'hA5A5A5A5; rd_addr1 = 5'd7;
      #1;
      chk("bypass data", rd_data1_a, 32'hA5A5A5A5);
      chk("no-bypass data", rd_data1_b, 32'h11);
      cycle();
      idle();

      alloc_en = 1'b1; alloc_addr = 5'd3;
      cycle();
      idle(); rd_addr1 = 5'd3;
      #1;
      chk("alloc r3 pend", {31'd0, rd_pend1_a}, 32'd1);
      cycle();
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = $urandom;
      cycle();
      idle();
      #1;
      chk("write r3 pend", {31'd0, rd_pend1_a}, 32'd0);
      cycle();

      alloc_en = 1'b1; alloc_addr = 5'd4; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
      cycle();
      idle(); rd_addr1 = 5'd4;
      #1;
      chk("alloc+write pend", {31'd0, rd_pend1_a}, 32'd1);
      cycle();

      alloc_en = 1'b1; alloc_addr = 5'd8;
      cycle();
      alloc_addr = 5'd9;
      cycle();
      idle(); flush = 1'b1;
      cycle();
      idle(); rd_addr1 = 5'd8; rd_addr2 = 5'd9;
      #1;
      chk("flush r8 pend", {31'd0, rd_pend1_a}, 32'd0);
      chk("flush r9 pend", {31'd0, rd_pend2_a}, 32'd0);
      cycle();

      alloc_en = 1'b1; alloc_addr = 5'd11;
      cycle();
      flush = 1'b1; alloc_addr = 5'd10;
      cycle();
      idle(); rd_addr1 = 5'd10; rd_addr2 = 5'd11;
      #1;
      chk("flush+alloc r10", {31'd0, rd_pend1_a}, 32'd1);
      chk("flush+alloc r11", {31'd0, rd_pend2_a}, 32'd0);
      cycle();

      for (int i = 1; i < DEPTH; i++) begin
         wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'hC000_0000 | 32'(i * 37);
         alloc_en = (i % 3 == 0); alloc_addr = 5'(i);
         cycle();
      end
      idle(); clr_req = 1'b1;
      cycle();
      idle();
      low = 0; done = 0;
      for (int c = 0; c < 40; c++) begin
         wr_en = (c == 3); wr_addr = 5'd20; wr_data = 32'hFFFF_FFFF;
         alloc_en = (c == 4); alloc_addr = 5'd21;
         flush = (c == 6);
         clr_req = (c >= 30 && c <= 32);
         rd_addr1 = 5'(c % DEPTH); rd_addr2 = 5'd20;
         #1;
         if (!rdy_a) low++;
         if (clr_done_a) done++;
         cycle();
      end
      idle();
      chk("clear rdy-low cycles", 32'(low), 32'd33);
      chk("clear done pulses", 32'(done), 32'd1);
      for (int a = 0; a < DEPTH; a++) begin
         rd_addr1 = 5'(a); rd_addr2 = 5'(DEPTH - 1 - a);
         #1;
         chk("clear readback", rd_data1_a, 32'd0);
         chk("clear pend", {31'd0, rd_pend1_a}, 32'd0);
         cycle();
      end

      for (int i = 1; i < DEPTH; i++) begin
         wr_en = 1'b1; wr_addr = 5'(i); wr_data = $urandom | 32'h1;
         cycle();
      end
      idle(); clr_req = 1'b1;
      cycle();
      idle();
      for (int c = 0; c < 10; c++) cycle();
      reset = 1'b1;
      cycle();
      idle();
      #1;
      chk("mid-clear reset rdy", {31'd0, rdy_a}, 32'd1);
      for (int c = 0; c < 40; c++) begin
         rd_addr1 = 5'(c % DEPTH); rd_addr2 = 5'((c + 7) % DEPTH);
         #1;
         chk("mid-clear no done", {31'd0, clr_done_a}, 32'd0);
         chk("mid-clear readback", rd_data1_b, 32'd0);
         cycle();
      end

      for (int n = 0; n < 1500; n++) begin
         reset      = ($urandom_range(0, 199) == 0);
         wr_en      = 1'($urandom_range(0, 1));
         wr_addr    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         wr_data    = $urandom;
         alloc_en   = ($urandom_range(0, 2) == 0);
         alloc_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
         flush      = ($urandom_range(0, 19) == 0);
         clr_req    = ($urandom_range(0, 99) == 0);
         rd_addr1   = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom);
         rd_addr2   = ($urandom_range(0, 2) == 0) ? alloc_addr : 5'($urandom);
         cycle();
      end
      idle();
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with a per-register pending scoreboard, write-first read bypass and a sequential bulk-clear engine. It is the next-generation replacement for the processor's 32x32 two-read/one-write register file. It sits between decode (reads, destination allocation) and writeback (writes, scoreboard release). The scoreboard lets the control unit detect read-after-write hazards on multi-cycle results without external tracking.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth DEPTH = 2^ADDR_W
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes and allocation; 0: register 0 is ordinary
- BYPASS, 1, 1: same-cycle write data forwarded to read ports; 0: reads return stored value only

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- rd_addr1, rd_addr2  in  ADDR_W  read addresses
- rd_data1, rd_data2  out  DATA_W  read data (combinational)
- rd_pend1, rd_pend2  out  1  addressed register has an outstanding producer
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- alloc_en  in  1  mark alloc_addr pending (instruction issued with this destination)
- alloc_addr  in  ADDR_W  destination being allocated
- flush  in  1  clear every pending bit (pipeline flush); data untouched
- clr_req  in  1  start bulk clear of data and pending bits
- rdy  out  1  1 when idle; 0 while clearing; wr_en/alloc_en ignored when 0
- clr_done  out  1  one-cycle pulse when the bulk clear completes

## Operation
- Storage: DEPTH x DATA_W data array and DEPTH pending bits.
- Write: when wr_en & rdy, mem[wr_addr] <= wr_data at the edge and pend[wr_addr] <= 0. With ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read: rd_dataN = mem[rd_addrN], subject to two overrides:
  - ZERO_REG=1 and rd_addrN=0 gives 0.
  - BYPASS=1, wr_en & rdy and wr_addr==rd_addrN (and not the zero register) gives wr_data.
- Pending: rd_pendN = pend[rd_addrN], subject to two overrides:
  - With a qualifying bypass hit, rd_pendN = 0.
  - Zero register (ZERO_REG=1) always 0.
- Allocate: when alloc_en & rdy, pend[alloc_addr] <= 1 (dropped for the zero register when ZERO_REG=1).
- Simultaneous alloc and write to the same address: alloc wins, so the bit ends at 1 because a new producer supersedes.
- Flush: all pend <= 0.
- flush together with alloc_en in the same cycle: flush clears all, then the alloc sets its bit, so only the alloc bit ends at 1.
- A write in the same cycle as flush still updates data.
- FSM states:
  - IDLE: rdy=1. clr_req moves to CLEAR with idx <= 0.
  - CLEAR: rdy=0. Each cycle mem[idx] <= 0 and pend[idx] <= 0, then idx <= idx+1. When idx == DEPTH-1, go to DONE.
  - DONE: rdy=0, clr_done=1 for exactly one cycle, then IDLE.
- clr_req is ignored outside IDLE.
- flush during CLEAR is still honoured.
- Reads stay valid throughout a clear and return the array's current contents; no bypass applies, because writes are ignored.
- idx is ADDR_W bits wide and is never allowed to wrap within one clear.

## Timing
- Reset, synchronous, takes priority over everything:
  - All mem and pend are zeroed.
  - FSM goes to IDLE, idx=0, rdy=1, clr_done=0.
  - After reset, rd_data*=0 and rd_pend*=0.
- Reset mid-clear aborts the clear; the next cycle is IDLE with all contents 0 and no clr_done pulse.
- Read latency 0 (combinational). Write visible through the array on the cycle after the edge, or the same cycle via bypass.
- Bulk clear: clr_req sampled at edge T0 gives rdy=0 from T0. The zeroing runs over DEPTH edges (T1..T_DEPTH). clr_done is high during the cycle after the last zeroing edge. rdy returns to 1 one cycle later.
- Total unavailability is DEPTH+1 cycles (33 for the defaults).
- Writes and allocs presented while rdy=0 are lost. The issuer must hold them until rdy=1.

## Test plan
- Basic write/read: reset, write r5=0xDEADBEEF, then read r5 on both ports next cycle. Requires 0xDEADBEEF on both ports and rd_pend=0.
- Zero register: write r0=0x1234 and alloc r0 (ZERO_REG=1). Requires rd_data1(r0)=0 and rd_pend1=0. Repeat with ZERO_REG=0: requires 0x1234.
- Bypass: in the same cycle wr_en r7=0xA5A5A5A5 with rd_addr1=7 (old value 0x11). Requires rd_data1=0xA5A5A5A5 combinationally with BYPASS=1, and 0x11 with BYPASS=0.
- Scoreboard: alloc r3, check rd_pend=1; write r3, check rd_pend=0 next cycle. Alloc and write r4 in the same cycle gives pend[r4]=1. Alloc r8 and r9, then flush, gives both pending bits 0.
- Bulk clear: fill r1..r31 with non-zero values, pulse clr_req. Requires rdy=0 for 33 cycles, clr_done high for exactly 1 cycle, all reads 0 afterwards, and a wr_en during the clear has no effect.
- Reset mid-clear: assert reset at clear cycle 10. Requires rdy=1 the next cycle, no clr_done pulse, and all registers reading 0.
